alu_mdu_seq: RTL

ALU_MDU_SEQ -- requirements
Module: alu_mdu_seq

---
 rtl/alu_mdu_seq_if.sv | 26 ++
 rtl/alu_mdu_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_seq_if.sv
// Request/result bundle for alu_mdu_seq: request handshake, operands, flush and
// the result handshake with its sum/overflow payload.
interface alu_mdu_seq_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] r1;
  logic [XLEN-1:0] r2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] sum;
  logic            overflow;

  modport master (
    output in_valid, op, r1, r2, flush, out_ready,
    input  in_ready, out_valid, sum, overflow
  );

  modport slave (
    input  in_valid, op, r1, r2, flush, out_ready,
    output in_ready, out_valid, sum, overflow
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// Sequential ALU with a one-cycle integer datapath and an iterative
// multiply/divide unit (shift-add multiply, restoring divide, one bit per cycle).
module alu_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic         clk,
  input logic         rst,
  alu_mdu_seq_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        mdu_op_reg;
  logic [XLEN-1:0]   a_reg;
  logic [XLEN-1:0]   hi_reg;
  logic [XLEN-1:0]   lo_reg;
  logic [XLEN-1:0]   dsr_reg;
  logic              neg_q_reg;
  logic              neg_r_reg;
  logic              div_zero_reg;
  logic [XLEN-1:0]   sum_reg;
  logic              ovf_reg;

  logic              accept;
  logic              is_mdu;
  logic              last_iter;
  logic              ready_int;
  logic              valid_int;

  assign is_mdu    = (bus.op[4:3] == 2'b10);
  assign accept    = bus.in_valid && (state_reg == IDLE) && !bus.flush;
  assign last_iter = (cnt_reg == CNT_W'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready_int  = 1'b0;
    valid_int  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_int = 1'b1;
        if (accept) state_next = is_mdu ? BUSY : DONE;
      end
      BUSY: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        valid_int = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  assign bus.in_ready  = ready_int;
  assign bus.out_valid = valid_int;
  assign bus.sum       = sum_reg;
  assign bus.overflow  = ovf_reg;

  // Single-cycle operations, evaluated straight from the request inputs.
  logic [XLEN-1:0] add_res, sub_res, alu_res;
  logic            alu_ovf;
  logic [SH_W-1:0] shamt;

  assign add_res = bus.r1 + bus.r2;
  assign sub_res = bus.r1 - bus.r2;
  assign shamt   = bus.r2[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      5'h00: begin
        alu_res = add_res;
        alu_ovf = (bus.r1[XLEN-1] == bus.r2[XLEN-1]) && (add_res[XLEN-1] != bus.r1[XLEN-1]);
      end
      5'h01: begin
        alu_res = sub_res;
        alu_ovf = (bus.r1[XLEN-1] != bus.r2[XLEN-1]) && (sub_res[XLEN-1] != bus.r1[XLEN-1]);
      end
      5'h02: alu_res = ~bus.r1;
      5'h03: alu_res = bus.r1 & bus.r2;
      5'h04: alu_res = bus.r1 | bus.r2;
      5'h05: alu_res = bus.r1 ^ bus.r2;
      5'h06: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.r1) < $signed(bus.r2))};
      5'h07: alu_res = {{(XLEN-1){1'b0}}, (bus.r1 < bus.r2)};
      5'h08: alu_res = bus.r1 << shamt;
      5'h09: alu_res = bus.r1 >> shamt;
      5'h0A: alu_res = XLEN'($signed(bus.r1) >>> shamt);
      default: ;
    endcase
  end

  // The iterative unit works on magnitudes; signs are reapplied at the end.
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = (bus.op[2:0] == 3'd1) || (bus.op[2:0] == 3'd2) ||
            (bus.op[2:0] == 3'd4) || (bus.op[2:0] == 3'd6);
    b_sgn = (bus.op[2:0] == 3'd1) || (bus.op[2:0] == 3'd4) || (bus.op[2:0] == 3'd6);
    a_neg = a_sgn && bus.r1[XLEN-1];
    b_neg = b_sgn && bus.r2[XLEN-1];
    a_mag = a_neg ? -bus.r1 : bus.r1;
    b_mag = b_neg ? -bus.r2 : bus.r2;
  end

  logic [XLEN:0]     mul_sum, div_rs, div_diff;
  logic [XLEN-1:0]   hi_step, lo_step, quo, rem, fin_res;
  logic [2*XLEN-1:0] prod, prod_fin;

  always_comb begin
    mul_sum  = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? dsr_reg : {XLEN{1'b0}})};
    div_rs   = {hi_reg, lo_reg[XLEN-1]};
    div_diff = div_rs - {1'b0, dsr_reg};
    if (mdu_op_reg[2]) begin
      hi_step = div_diff[XLEN] ? div_rs[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_step = {lo_reg[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
    // Final result is formed from the last iteration's output directly.
    prod     = {hi_step, lo_step};
    prod_fin = neg_q_reg ? -prod : prod;
    quo      = neg_q_reg ? -lo_step : lo_step;
    rem      = neg_r_reg ? -hi_step : hi_step;
    case (mdu_op_reg)
      3'd0:       fin_res = prod_fin[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       fin_res = prod_fin[2*XLEN-1:XLEN];
      3'd4, 3'd5: fin_res = div_zero_reg ? {XLEN{1'b1}} : quo;
      default:    fin_res = div_zero_reg ? a_reg : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      mdu_op_reg   <= '0;
      a_reg        <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      dsr_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      sum_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      if (state_reg == BUSY) begin
        hi_reg  <= hi_step;
        lo_reg  <= lo_step;
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (last_iter) begin
          sum_reg <= fin_res;
          ovf_reg <= 1'b0;
        end
      end
      if (accept) begin
        mdu_op_reg   <= bus.op[2:0];
        a_reg        <= bus.r1;
        hi_reg       <= '0;
        lo_reg       <= a_mag;
        dsr_reg      <= b_mag;
        neg_q_reg    <= a_neg ^ b_neg;
        neg_r_reg    <= a_neg;
        div_zero_reg <= (bus.r2 == '0);
        cnt_reg      <= '0;
        if (!is_mdu) begin
          sum_reg <= alu_res;
          ovf_reg <= alu_ovf;
        end
      end
    end
  end
endmodule
